// File: rtl/aes_pkg.sv
// Shared AES constants and tables; the InvSubBytes stage uses the 8-bit inverse S-box
// table and the stage FSM encoding declared here.
package aes_pkg;
  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = 16;

  typedef logic [0:STATE_W-1] state_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} isb_state_e;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Upstream/downstream valid-ready bundle for the InvSubBytes stage; slave is the stage side.
interface inv_sub_bytes_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t state_in;
  logic   out_valid;
  logic   out_ready;
  state_t state_out;
  logic   busy;

  modport master (output in_valid, state_in, out_ready,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, out_ready,
                  output in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Combinational FIPS-197 inverse S-box lookup, one byte in, one byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);
  assign dout = INV_SBOX[din];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES shared inverse S-boxes sweep the 16 state bytes in 16/LANES cycles.
// Optional macro AES_INV_SB_ZEROIZE_EN clears the result register once downstream takes it.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  inv_sub_bytes_iter_if.slave bus
);
  localparam int NGRP  = NBYTES / LANES;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e       state_q, state_d;
  state_t           data_q, data_d;
  logic [GRP_W-1:0] grp_q, grp_d;

  byte_t lane_in  [LANES];
  byte_t lane_out [LANES];

  // Lane l always serves byte grp*LANES + l of the working register.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = data_q[BYTE_W*(int'(grp_q)*LANES + l) +: BYTE_W];
    inv_sbox u_inv_sbox (.din(lane_in[l]), .dout(lane_out[l]));
  end

  // NOTE: combinational logic uses blocking '=' and defaults every target first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grp_d   = grp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.state_in;
          grp_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[BYTE_W*(int'(grp_q)*LANES + l) +: BYTE_W] = lane_out[l];
        end
        if (int'(grp_q) == NGRP - 1) begin
          grp_d   = '0;
          state_d = ST_DONE;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
`ifdef AES_INV_SB_ZEROIZE_EN
          data_d = '0;
`else
          data_d = data_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the 128-bit working register is reset too, so state_out is a known 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grp_q   <= grp_d;
    end
  end

  // Handshake outputs come from the state register alone: no input-to-output paths.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state_out = data_q;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter; the reference inverse S-box is computed from GF(2^8)
// arithmetic here rather than taken from the design's table.
module tb_inv_sub_bytes_iter;
  typedef logic [0:127] blk_t;

  localparam blk_t C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam blk_t C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  blk_t sb_q[$];

  inv_sub_bytes_iter_if if_m ();
  inv_sub_bytes_iter_if if_l1 ();
  inv_sub_bytes_iter_if if_l2 ();
  inv_sub_bytes_iter_if if_l8 ();
  inv_sub_bytes_iter_if if_l16 ();

  inv_sub_bytes_iter #(.LANES(4))  u_dut (.clk(clk), .rst(rst), .bus(if_m.slave));
  inv_sub_bytes_iter #(.LANES(1))  u_l1  (.clk(clk), .rst(rst), .bus(if_l1.slave));
  inv_sub_bytes_iter #(.LANES(2))  u_l2  (.clk(clk), .rst(rst), .bus(if_l2.slave));
  inv_sub_bytes_iter #(.LANES(8))  u_l8  (.clk(clk), .rst(rst), .bus(if_l8.slave));
  inv_sub_bytes_iter #(.LANES(16)) u_l16 (.clk(clk), .rst(rst), .bus(if_l16.slave));

  logic ov [5];
  blk_t so [5];
  assign ov[0] = if_l1.out_valid;  assign so[0] = if_l1.state_out;
  assign ov[1] = if_l2.out_valid;  assign so[1] = if_l2.state_out;
  assign ov[2] = if_m.out_valid;   assign so[2] = if_m.state_out;
  assign ov[3] = if_l8.out_valid;  assign so[3] = if_l8.state_out;
  assign ov[4] = if_l16.out_valid; assign so[4] = if_l16.state_out;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] inv_sbox_ref(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic blk_t inv_sub_ref(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox_ref(s[8*i +: 8]);
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input blk_t d, input bit keep_valid, output bit ok);
    ok = 1'b0;
    if_m.state_in = d;
    if_m.in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (if_m.in_ready) begin
        tick();
        sb_q.push_back(inv_sub_ref(d));
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    if (!keep_valid) if_m.in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: in_ready never seen for block %h", d);
    end
  endtask

  task automatic wait_output(input string tag, output int lat, output blk_t got);
    blk_t exp;
    lat = 0;
    while (!if_m.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    got = if_m.state_out;
    total++;
    if (if_m.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: out_valid=%b want 1", tag, if_m.out_valid);
      return;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s_data: got %h want %h", tag, got, exp);
    end
    if (if_m.out_ready) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (if_m.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", if_m.in_ready); end
    total++; if (if_m.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", if_m.out_valid); end
    total++; if (if_m.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", if_m.busy); end
    total++; if (if_m.state_out !== '0) begin bad++; $display("FAIL rst_state_out: got %h want 0", if_m.state_out); end
  endtask

  task automatic test_zero_block();
    bit   ok;
    int   lat;
    int   low;
    blk_t got;
    blk_t exp;
    if_m.out_ready = 1'b1;
    drive_block('0, 1'b0, ok);
    total++; if (if_m.busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b want 1", if_m.busy); end
    lat = -1; low = 0; got = 'x;
    for (int n = 0; n < 50; n++) begin
      if (if_m.out_valid && lat < 0) begin lat = n; got = if_m.state_out; end
      if (!if_m.in_ready) low++;
      else break;
      tick();
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_latency: got %0d want 4", lat); end
    total++; if (low !== 5) begin bad++; $display("FAIL zero_in_ready_low: got %0d want 5", low); end
    total++; if (got !== exp) begin bad++; $display("FAIL zero_data_model: got %h want %h", got, exp); end
    total++; if (got !== {16{8'h52}}) begin bad++; $display("FAIL zero_data_52: got %h want all 52", got); end
  endtask

  task automatic test_lanes();
    int   lat [5];
    blk_t got [5];
    int   exp_lat [5];
    exp_lat = '{16, 8, 4, 2, 1};
    for (int i = 0; i < 5; i++) begin lat[i] = -1; got[i] = 'x; end
    if_l1.state_in = C1_IN; if_l2.state_in = C1_IN; if_m.state_in = C1_IN;
    if_l8.state_in = C1_IN; if_l16.state_in = C1_IN;
    if_l1.out_ready = 1'b1; if_l2.out_ready = 1'b1; if_m.out_ready = 1'b1;
    if_l8.out_ready = 1'b1; if_l16.out_ready = 1'b1;
    if_l1.in_valid = 1'b1; if_l2.in_valid = 1'b1; if_m.in_valid = 1'b1;
    if_l8.in_valid = 1'b1; if_l16.in_valid = 1'b1;
    tick();
    if_l1.in_valid = 1'b0; if_l2.in_valid = 1'b0; if_m.in_valid = 1'b0;
    if_l8.in_valid = 1'b0; if_l16.in_valid = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        if (ov[i] && lat[i] < 0) begin lat[i] = n; got[i] = so[i]; end
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (lat[i] !== exp_lat[i]) begin
        bad++; $display("FAIL c1_latency_ngrp%0d: got %0d want %0d", exp_lat[i], lat[i], exp_lat[i]);
      end
      total++;
      if (got[i] !== C1_OUT) begin
        bad++; $display("FAIL c1_data_ngrp%0d: got %h want %h", exp_lat[i], got[i], C1_OUT);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   n;
    int   lat;
    blk_t held;
    blk_t got;
    blk_t blk_b;
    blk_b = 128'h0123456789abcdeffedcba9876543210;
    if_m.out_ready = 1'b0;
    drive_block(128'h00112233445566778899aabbccddeeff, 1'b0, ok);
    n = 0;
    while (!if_m.out_valid && n < 100) begin tick(); n++; end
    total++; if (if_m.out_valid !== 1'b1) begin bad++; $display("FAIL bp_done_timeout: out_valid=%b want 1", if_m.out_valid); end
    held = if_m.state_out;
    if_m.state_in = blk_b;
    if_m.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (if_m.state_out !== held) begin bad++; $display("FAIL bp_stable c%0d: got %h want %h", c, if_m.state_out, held); end
      total++; if (if_m.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, if_m.in_ready); end
      total++; if (if_m.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, if_m.out_valid); end
    end
    wait_output("bp_a", lat, got);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;
    total++; if (if_m.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_in_ready: got %b want 1", if_m.in_ready); end
    tick();
    sb_q.push_back(inv_sub_ref(blk_b));
    if_m.in_valid = 1'b0;
    total++; if (if_m.busy !== 1'b1) begin bad++; $display("FAIL bp_b_accept_busy: got %b want 1", if_m.busy); end
    if_m.out_ready = 1'b1;
    wait_output("bp_b", lat, got);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_b_latency: got %0d want 4", lat); end
  endtask

  task automatic test_reset_mid_run();
    bit   ok;
    int   lat;
    blk_t got;
    if_m.out_ready = 1'b1;
    drive_block({16{8'h63}}, 1'b0, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    total++; if (if_m.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", if_m.out_valid); end
    total++; if (if_m.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", if_m.busy); end
    total++; if (if_m.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", if_m.in_ready); end
    total++; if (if_m.state_out !== '0) begin bad++; $display("FAIL mid_rst_buf: got %h want 0", if_m.state_out); end
    drive_block({16{8'h63}}, 1'b0, ok);
    wait_output("mid_rst_fresh", lat, got);
    total++; if (got !== '0) begin bad++; $display("FAIL mid_rst_fresh_zero: got %h want 0", got); end
  endtask

  task automatic test_back_to_back();
    bit   ok1;
    bit   ok2;
    int   l0;
    int   l1;
    blk_t g0;
    blk_t g1;
    blk_t w0;
    blk_t w1;
    int   extra;
    w0 = 128'h000102030405060708090a0b0c0d0e0f;
    w1 = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
    if_m.out_ready = 1'b1;
    fork
      begin
        drive_block(w0, 1'b1, ok1);
        drive_block(w1, 1'b0, ok2);
      end
      begin
        wait_output("b2b_first", l0, g0);
        wait_output("b2b_second", l1, g1);
      end
    join
    total++; if (g0[0:31] !== 32'h52096ad5) begin bad++; $display("FAIL b2b_first_head: got %h want 52096ad5", g0[0:31]); end
    total++; if (g1[0:31] !== 32'h7d0c2155) begin bad++; $display("FAIL b2b_second_head: got %h want 7d0c2155", g1[0:31]); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_m.out_valid) extra++;
    end
    total++; if (extra !== 0 || sb_q.size() !== 0) begin
      bad++; $display("FAIL b2b_no_dup: extra_valid=%0d pending=%0d want 0/0", extra, sb_q.size());
    end
  endtask

  task automatic test_zeroize();
    bit   ok;
    int   lat;
    blk_t got;
    blk_t exp_idle;
    if_m.out_ready = 1'b1;
    drive_block(C1_IN, 1'b0, ok);
    wait_output("zero_blk", lat, got);
    tick();
`ifdef AES_INV_SB_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = C1_OUT;
`endif
    total++; if (if_m.in_ready !== 1'b1) begin bad++; $display("FAIL zeroize_idle: in_ready=%b want 1", if_m.in_ready); end
    total++; if (if_m.state_out !== exp_idle) begin bad++; $display("FAIL zeroize_state_out: got %h want %h", if_m.state_out, exp_idle); end
  endtask

  initial begin
    if_m.in_valid = 1'b0;   if_m.state_in = '0;   if_m.out_ready = 1'b0;
    if_l1.in_valid = 1'b0;  if_l1.state_in = '0;  if_l1.out_ready = 1'b0;
    if_l2.in_valid = 1'b0;  if_l2.state_in = '0;  if_l2.out_ready = 1'b0;
    if_l8.in_valid = 1'b0;  if_l8.state_in = '0;  if_l8.out_ready = 1'b0;
    if_l16.in_valid = 1'b0; if_l16.state_in = '0; if_l16.out_ready = 1'b0;
    test_reset();
    test_zero_block();
    test_lanes();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_zeroize();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
